// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
// Latches the EXE->MEM bus, picks up the synchronous data-SRAM read word,
// aligns/extends load data and forwards results and status to ID/EXE/WB.
// A one-entry buffer keeps the SRAM word alive while WB back-pressures,
// because the SRAM only presents the word for one cycle.

module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 169,
    parameter int MS_TO_WS_BUS_WD = 156
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic [4:0]                 MEM_dest,
    output logic [31:0]                MEM_result,
    output logic                       ms_load_op,
    output logic                       ms_inst_mfc0,
    output logic                       ms_ex,
    output logic                       ms_inst_eret
);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic                       ms_valid;
    logic                       ms_ready_go;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

    // Read-data buffer state
    logic                       buf_v;
    logic [31:0]                rdata_buf;
    logic [31:0]                rd_word;

    // Decoded fields of the latched EXE->MEM bus
    logic [3:0]                 ms_tlb_ops;
    logic [31:0]                ms_badvaddr;
    logic [4:0]                 ms_mfc0_rd;
    logic                       ms_ex_bit;
    logic [4:0]                 ms_exccode;
    logic                       ms_bd;
    logic                       ms_eret;
    logic [2:0]                 ms_sel;
    logic                       ms_mtc0;
    logic                       ms_mfc0;
    logic [31:0]                ms_rt_value;
    logic [11:0]                ms_mem_inst;
    logic                       ms_res_from_mem;
    logic                       ms_gr_we;
    logic [4:0]                 ms_dest;
    logic [31:0]                ms_alu_result;
    logic [31:0]                ms_pc;

    // Load decode and alignment
    logic                       inst_lw;
    logic                       inst_lb;
    logic                       inst_lbu;
    logic                       inst_lh;
    logic                       inst_lhu;
    logic                       inst_lwl;
    logic                       inst_lwr;
    logic [1:0]                 addr_low;
    logic [7:0]                 load_byte;
    logic [15:0]                load_half;
    logic [31:0]                lwl_result;
    logic [31:0]                lwr_result;
    logic [31:0]                load_result;
    logic [31:0]                final_result;

    // Store opcodes and the lw/sw split are consumed upstream; only loads matter here
    logic                       unused_store_bits;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Stage valid flag: flush empties the stage ahead of any new arrival
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Bus register: clears on flush so no stale status leaks to the outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_to_ms_bus_r <= '0;
        end else if (flush) begin
            es_to_ms_bus_r <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // Capture the SRAM word on the first stalled cycle and hold it until the instruction leaves
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_v     <= 1'b0;
            rdata_buf <= 32'h0;
        end else if (flush) begin
            buf_v     <= 1'b0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            buf_v     <= 1'b0;
        end else if (ms_valid && !ws_allowin && !buf_v) begin
            buf_v     <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    assign rd_word = buf_v ? rdata_buf : data_sram_rdata;

    // ------------------------------------------------------------------
    // Bus field extraction
    // ------------------------------------------------------------------
    assign ms_tlb_ops      = es_to_ms_bus_r[168:165];
    assign ms_badvaddr     = es_to_ms_bus_r[164:133];
    assign ms_mfc0_rd      = es_to_ms_bus_r[132:128];
    assign ms_ex_bit       = es_to_ms_bus_r[127];
    assign ms_exccode      = es_to_ms_bus_r[126:122];
    assign ms_bd           = es_to_ms_bus_r[121];
    assign ms_eret         = es_to_ms_bus_r[120];
    assign ms_sel          = es_to_ms_bus_r[119:117];
    assign ms_mtc0         = es_to_ms_bus_r[116];
    assign ms_mfc0         = es_to_ms_bus_r[115];
    assign ms_rt_value     = es_to_ms_bus_r[114:83];
    assign ms_mem_inst     = es_to_ms_bus_r[82:71];
    assign ms_res_from_mem = es_to_ms_bus_r[70];
    assign ms_gr_we        = es_to_ms_bus_r[69];
    assign ms_dest         = es_to_ms_bus_r[68:64];
    assign ms_alu_result   = es_to_ms_bus_r[63:32];
    assign ms_pc           = es_to_ms_bus_r[31:0];

    assign inst_lw  = ms_mem_inst[0];
    assign inst_lb  = ms_mem_inst[2];
    assign inst_lbu = ms_mem_inst[3];
    assign inst_lh  = ms_mem_inst[4];
    assign inst_lhu = ms_mem_inst[5];
    assign inst_lwl = ms_mem_inst[6];
    assign inst_lwr = ms_mem_inst[7];

    assign unused_store_bits = ^{ms_mem_inst[1], ms_mem_inst[11:8]};

    assign addr_low  = ms_alu_result[1:0];
    assign load_half = addr_low[1] ? rd_word[31:16] : rd_word[15:0];

    // ------------------------------------------------------------------
    // Load alignment
    // ------------------------------------------------------------------

    // Byte lane select for lb/lbu
    always_comb begin
        load_byte = 8'h00;
        case (addr_low)
            2'd0:    load_byte = rd_word[7:0];
            2'd1:    load_byte = rd_word[15:8];
            2'd2:    load_byte = rd_word[23:16];
            default: load_byte = rd_word[31:24];
        endcase
    end

    // Unaligned word merges: lwl fills from the top, lwr from the bottom, rest kept from rt
    always_comb begin
        lwl_result = rd_word;
        lwr_result = rd_word;
        case (addr_low)
            2'd0: begin
                lwl_result = {rd_word[7:0],  ms_rt_value[23:0]};
                lwr_result = rd_word;
            end
            2'd1: begin
                lwl_result = {rd_word[15:0], ms_rt_value[15:0]};
                lwr_result = {ms_rt_value[31:24], rd_word[31:8]};
            end
            2'd2: begin
                lwl_result = {rd_word[23:0], ms_rt_value[7:0]};
                lwr_result = {ms_rt_value[31:16], rd_word[31:16]};
            end
            default: begin
                lwl_result = rd_word;
                lwr_result = {ms_rt_value[31:8], rd_word[31:24]};
            end
        endcase
    end

    // Pick the load flavour and apply sign or zero extension
    always_comb begin
        load_result = rd_word;
        if (inst_lb) begin
            load_result = {{24{load_byte[7]}}, load_byte};
        end else if (inst_lbu) begin
            load_result = {24'h0, load_byte};
        end else if (inst_lh) begin
            load_result = {{16{load_half[15]}}, load_half};
        end else if (inst_lhu) begin
            load_result = {16'h0, load_half};
        end else if (inst_lwl) begin
            load_result = lwl_result;
        end else if (inst_lwr) begin
            load_result = lwr_result;
        end else if (inst_lw) begin
            load_result = rd_word;
        end
    end

    assign final_result = ms_res_from_mem ? load_result : ms_alu_result;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // An excepting instruction must never write the register file
    assign ms_to_ws_bus = {ms_tlb_ops,
                           ms_ex_bit,
                           ms_exccode,
                           ms_bd,
                           ms_eret,
                           ms_sel,
                           ms_mtc0,
                           ms_mfc0,
                           ms_mfc0_rd,
                           ms_rt_value,
                           ms_badvaddr,
                           ms_gr_we & ~ms_ex_bit,
                           ms_dest,
                           final_result,
                           ms_pc};

    assign MEM_dest     = ms_dest & {5{ms_valid & ms_gr_we}};
    assign MEM_result   = final_result;
    assign ms_load_op   = ms_valid & ms_res_from_mem;
    assign ms_inst_mfc0 = ms_valid & ms_mfc0;
    assign ms_ex        = ms_valid & ms_ex_bit;
    assign ms_inst_eret = ms_valid & ms_eret;

endmodule
